// File: rtl/mult_pkg.sv
// Shared types and helpers for the shift-add multiplier family.
package mult_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter must hold values 0..W, hence W+1 distinct codes.
  function automatic int cnt_width(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/shift_add_datapath.sv
// Operand registers, conditional add/shift step and final sign fix-up for
// the radix-2 shift-add multiplier.
module shift_add_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               step,
  input  logic               fix,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] product
);

  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   acc_hi;
  logic [WIDTH-1:0]   mplr;
  logic               neg;
  logic               sm_eff;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] raw;

  assign sm_eff = SIGNED_EN && signed_mode;

  // -2^(W-1) negates to itself, which read unsigned is the correct magnitude.
  always_comb begin
    a_mag = a;
    b_mag = b;
    if (sm_eff && a[WIDTH-1]) a_mag = -a;
    if (sm_eff && b[WIDTH-1]) b_mag = -b;
  end

  // The carry lives in sum[WIDTH] and is shifted straight into acc_hi.
  assign sum = {1'b0, acc_hi} + (mplr[0] ? {1'b0, mcand} : '0);
  assign raw = {acc_hi, mplr};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mcand   <= '0;
      acc_hi  <= '0;
      mplr    <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (load) begin
      mcand  <= a_mag;
      mplr   <= b_mag;
      acc_hi <= '0;
      neg    <= sm_eff && (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      acc_hi <= sum[WIDTH:1];
      mplr   <= {sum[0], mplr[WIDTH-1:1]};
    end else if (fix) begin
      product <= neg ? -raw : raw;
    end
  end

endmodule

// File: rtl/shift_add_mult_param.sv
// Parametrised sequential shift-add multiplier: control FSM, step counter
// and start/busy/done handshake around shift_add_datapath.
module shift_add_mult_param
  import mult_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product,
  output state_t             state_dbg
);

  localparam int CW = cnt_width(WIDTH);

  state_t          state;
  logic [CW-1:0]   count;
  logic            load;
  logic            step;
  logic            fix;

  // Handshake: start is accepted only in IDLE or DONE (busy low); busy stays
  // high through CALC and FIX; done pulses for one cycle as product updates.
  assign load      = start && (state == IDLE || state == DONE);
  assign step      = (state == CALC);
  assign fix       = (state == FIX);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            state <= CALC;
            count <= '0;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) state <= FIX;
        end
        FIX: begin
          state <= DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  shift_add_datapath #(
    .WIDTH     (WIDTH),
    .SIGNED_EN (SIGNED_EN)
  ) u_datapath (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .step        (step),
    .fix         (fix),
    .signed_mode (signed_mode),
    .a           (multiplicand),
    .b           (multiplier),
    .product     (product)
  );

endmodule

// File: tb/tb_shift_add_mult_param.sv
// Directed checks of shift_add_mult_param at W=8 (signed), W=4 (unsigned only)
// and W=16 against hand-computed products and a small arithmetic model.
module tb_shift_add_mult_param;
  import mult_pkg::*;

  logic clk;
  logic rst;

  logic        start8, sm8, busy8, done8;
  logic [7:0]  a8, b8;
  logic [15:0] p8;
  state_t      st8;

  logic        start4, sm4, busy4, done4;
  logic [3:0]  a4, b4;
  logic [7:0]  p4;
  state_t      st4;

  logic        start16, sm16, busy16, done16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  state_t      st16;

  int checks = 0;
  int errors = 0;

  shift_add_mult_param #(.WIDTH(8), .SIGNED_EN(1'b1)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .multiplicand(a8), .multiplier(b8), .busy(busy8), .done(done8),
    .product(p8), .state_dbg(st8)
  );

  shift_add_mult_param #(.WIDTH(4), .SIGNED_EN(1'b0)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .multiplicand(a4), .multiplier(b4), .busy(busy4), .done(done4),
    .product(p4), .state_dbg(st4)
  );

  shift_add_mult_param #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
    .multiplicand(a16), .multiplier(b16), .busy(busy16), .done(done16),
    .product(p16), .state_dbg(st16)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns just after the edge that samples start (t0 + 1ns).
  task automatic start_op8(input logic [7:0] a, input logic [7:0] b, input logic sm);
    @(negedge clk);
    start8 = 1'b1; a8 = a; b8 = b; sm8 = sm;
    @(posedge clk); #1;
    start8 = 1'b0;
  endtask

  // n = edges from the current sample point to the one raising done.
  task automatic wait_done8(output int n, output int busy_n);
    n = 0;
    busy_n = busy8 ? 1 : 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (busy8) busy_n++;
      if (done8) break;
    end
    if (!done8) check("timeout8", 0, 1);
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic sm,
                      input logic [15:0] exp, input string tag);
    int n, bn;
    start_op8(a, b, sm);
    wait_done8(n, bn);
    check({tag, "_lat"}, n, 9);
    check({tag, "_prod"}, p8, exp);
  endtask

  task automatic run4(input logic [3:0] a, input logic [3:0] b, input logic sm,
                      input logic [7:0] exp, input string tag);
    int n;
    @(negedge clk);
    start4 = 1'b1; a4 = a; b4 = b; sm4 = sm;
    @(posedge clk); #1;
    start4 = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n++;
      if (done4) break;
    end
    check({tag, "_lat"}, n, 5);
    check({tag, "_prod"}, p4, exp);
  endtask

  task automatic run16(input logic [15:0] a, input logic [15:0] b, input logic sm,
                       input logic [31:0] exp, input string tag);
    int n;
    @(negedge clk);
    start16 = 1'b1; a16 = a; b16 = b; sm16 = sm;
    @(posedge clk); #1;
    start16 = 1'b0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      n++;
      if (done16) break;
    end
    check({tag, "_lat"}, n, 17);
    check({tag, "_prod"}, p16, exp);
  endtask

  function automatic logic [31:0] model16(input logic [15:0] a, input logic [15:0] b,
                                          input logic sm);
    longint x, y, r;
    x = sm ? longint'($signed(a)) : longint'(a);
    y = sm ? longint'($signed(b)) : longint'(b);
    r = x * y;
    return r[31:0];
  endfunction

  initial begin
    int n, bn, extra;
    logic [15:0] ra, rb;
    logic        rs;

    rst = 1'b0;
    start8 = 0; sm8 = 0; a8 = 0; b8 = 0;
    start4 = 0; sm4 = 0; a4 = 0; b4 = 0;
    start16 = 0; sm16 = 0; a16 = 0; b16 = 0;
    #12;
    check("rst_busy", busy8, 0);
    check("rst_done", done8, 0);
    check("rst_prod", p8, 0);
    check("rst_state", st8, IDLE);
    @(negedge clk) rst = 1'b1;

    // unsigned 13*11 with busy width and done pulse length
    start_op8(8'd13, 8'd11, 1'b0);
    check("u13x11_state", st8, CALC);
    wait_done8(n, bn);
    check("u13x11_lat", n, 9);
    check("u13x11_busy", bn, 9);
    check("u13x11_prod", p8, 16'h008F);
    @(posedge clk); #1;
    check("u13x11_done_pulse", done8, 0);
    check("u13x11_idle", st8, IDLE);

    run8(8'd255, 8'd255, 1'b0, 16'hFE01, "umax");
    run8(8'hFD,  8'd5,   1'b1, 16'hFFF1, "s_m3x5");
    run8(8'h80,  8'h80,  1'b1, 16'h4000, "s_min_min");
    run8(8'h80,  8'h7F,  1'b1, 16'hC080, "s_min_max");
    run8(8'h80,  8'h80,  1'b0, 16'h4000, "u128x128");
    run8(8'd0,   8'hFF,  1'b1, 16'h0000, "zero");

    // start during CALC is ignored; product held until the new FIX
    start_op8(8'd13, 8'd11, 1'b0);
    @(negedge clk);
    start8 = 1'b1; a8 = 8'd2; b8 = 8'd3; sm8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    check("busy_prod_held", p8, 16'h0000);
    wait_done8(n, bn);
    check("busy_ign_prod", p8, 16'h008F);
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done8) extra++;
    end
    check("busy_ign_extra_done", extra, 0);

    // back-to-back: start accepted in the DONE cycle
    start_op8(8'hFD, 8'd5, 1'b1);
    wait_done8(n, bn);
    check("b2b_first", p8, 16'hFFF1);
    start_op8(8'd2, 8'd3, 1'b0);
    check("b2b_prod_stable", p8, 16'hFFF1);
    wait_done8(n, bn);
    check("b2b_spacing", n + 1, 10);
    check("b2b_prod", p8, 16'h0006);

    // asynchronous reset mid-operation
    start_op8(8'd100, 8'd100, 1'b0);
    repeat (3) @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    check("mid_rst_busy", busy8, 0);
    check("mid_rst_done", done8, 0);
    check("mid_rst_prod", p8, 0);
    check("mid_rst_state", st8, IDLE);
    @(negedge clk) rst = 1'b1;
    run8(8'd7, 8'd9, 1'b0, 16'd63, "after_rst");

    // W=4, signed mode compiled out
    run4(4'hF, 4'hF, 1'b1, 8'hE1, "w4_nosign");
    run4(4'd3, 4'd5, 1'b0, 8'h0F, "w4_3x5");

    // W=16 directed extremes plus random sweep
    run16(16'h8000, 16'h8000, 1'b1, 32'h4000_0000, "w16_min_min");
    run16(16'hFFFF, 16'hFFFF, 1'b0, 32'hFFFE_0001, "w16_umax");
    run16(16'hFFFF, 16'd2,    1'b1, 32'hFFFF_FFFE, "w16_m1x2");
    for (int i = 0; i < 12; i++) begin
      ra = 16'($urandom_range(0, 65535));
      rb = 16'($urandom_range(0, 65535));
      rs = 1'($urandom_range(0, 1));
      run16(ra, rb, rs, model16(ra, rb, rs), "w16_rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
